// File: rtl/mulseq_pkg.sv
// Shared types, funct3 encodings and operand-sign helpers for the iterative multiplier.
// XLEN matches the core integer width configuration (64).
package mulseq_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} statetype;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  function automatic logic a_is_signed(input logic [2:0] f3);
    case (f3)
      MUL_F3, MULH_F3, MULHSU_F3: return 1'b1;
      MULHU_F3:                   return 1'b0;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == MUL_F3) || (f3 == MULH_F3);
  endfunction

  // Magnitude as unsigned XLEN; the most negative value maps to 2^(XLEN-1) without overflow.
  function automatic logic [XLEN-1:0] abs_operand(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mulseq_mulstep.sv
// Combinational STEP-bit conditional shift-add: adds mcand<<i for each set multiplier bit i.
module mulstep
  import mulseq_pkg::*;
#(
  parameter int unsigned STEP = 2
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [2*XLEN-1:0] mcand,
  input  logic [STEP-1:0]   mbits,
  output logic [2*XLEN-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < int'(STEP); i++) begin
      if (mbits[i]) acc_next = acc_next + (mcand << i);
    end
  end

endmodule

// File: rtl/mulseq.sv
// Iterative shift-add multiply sequencer retiring STEP multiplier bits per cycle.
// Define MUL_EARLY_OUT_EN to leave BUSY as soon as the remaining multiplier bits are zero.
module mulseq
  import mulseq_pkg::*;
#(
  parameter int unsigned STEP = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallM,
  input  logic                FlushE,
  input  logic                FlushM,
  input  logic                MulStartE,
  input  logic [XLEN-1:0]     ForwardedSrcAE,
  input  logic [XLEN-1:0]     ForwardedSrcBE,
  input  logic [2:0]          Funct3E,
  output logic                MulBusyE,
  output logic [2*XLEN-1:0]   ProdM
);

  localparam int unsigned ITERS = XLEN / STEP;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  statetype            state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mult_q, mult_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [2*XLEN-1:0]   acc_step;
  logic                neg_a, neg_b, last_iter;

  mulstep #(.STEP(STEP)) u_mulstep (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .mbits    (mult_q[STEP-1:0]),
    .acc_next (acc_step)
  );

  // Stall request depends only on state and MulStartE, never on the operands.
  assign MulBusyE = ((state_q == IDLE) && MulStartE) || (state_q == BUSY) || (state_q == FIX);
  assign ProdM    = prod_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    count_d   = count_q;
    neg_d     = neg_q;
    last_iter = 1'b0;
    neg_a     = a_is_signed(Funct3E) && ForwardedSrcAE[XLEN-1];
    neg_b     = b_is_signed(Funct3E) && ForwardedSrcBE[XLEN-1];

    case (state_q)
      IDLE: begin
        if (MulStartE && !FlushE) begin
          mult_d  = abs_operand(ForwardedSrcBE, b_is_signed(Funct3E));
          mcand_d = {{XLEN{1'b0}}, abs_operand(ForwardedSrcAE, a_is_signed(Funct3E))};
          acc_d   = '0;
          count_d = '0;
          neg_d   = neg_a ^ neg_b;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << STEP;
        mult_d  = mult_q >> STEP;
        count_d = count_q + CNT_W'(1);
`ifdef MUL_EARLY_OUT_EN
        last_iter = (count_q == LAST_CNT) || (mult_d == '0);
`else
        last_iter = (count_q == LAST_CNT);
`endif
        if (last_iter) state_d = FIX;
      end
      FIX: begin
        if (neg_q) acc_d = -acc_q;
        state_d = DONE;
      end
      DONE: begin
        if (!StallM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (FlushE) state_d = IDLE;

    // Product register: clear wins over the DONE capture.
    if (FlushM)                            prod_d = '0;
    else if ((state_q == DONE) && !StallM) prod_d = acc_q;
    else                                   prod_d = prod_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: doc/mulseq.md
# mulseq

Iterative multiply sequencer for the Wally integer pipeline. It replaces the single-cycle product path with a shift-add engine that retires STEP multiplier bits per cycle. It holds the Execute stage with a busy/stall request while iterating and delivers the full 2·XLEN product into the Memory-stage product register. It sits beside the ALU in the IEU and is driven by the hazard unit's StallM/FlushE/FlushM.

## Interface
- STEP, 2: multiplier bits retired per iteration; legal values 1, 2, 4; must divide `XLEN.
- Width XLEN comes from `XLEN in wally-config.vh.
- Ports:
  - clk  in  1  core clock.
  - reset  in  1  synchronous, active-high; clears all state on the rising edge.
  - StallM  in  1  Memory stage stalled; ProdM holds.
  - FlushE  in  1  kill the in-flight multiply.
  - FlushM  in  1  clear ProdM.
  - MulStartE  in  1  valid multiply instruction in Execute.
  - ForwardedSrcAE  in  XLEN  multiplicand, forwarded.
  - ForwardedSrcBE  in  XLEN  multiplier, forwarded.
  - Funct3E  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - MulBusyE  out  1  stall request to the hazard unit.
  - ProdM  out  2·XLEN  product, Memory-stage registered.

## Operation
- **States:** IDLE, BUSY, FIX, DONE.
- **Signedness.**
  - A is signed for 000, 001 and 010.
  - B is signed for 000 and 001.
  - NegE = signA&A[msb] XOR signB&B[msb], latched at start.
- **IDLE → BUSY** when MulStartE & ~FlushE.
  - Load MultReg = |B| (XLEN unsigned).
  - Load McandReg = |A| zero-extended to 2·XLEN.
  - Clear Acc and Count.
  - |−2^(XLEN−1)| = 2^(XLEN−1) is representable unsigned; no overflow.
- **BUSY.** Each cycle:
  - Acc += Σ over i<STEP of MultReg[i] ? McandReg<<i : 0.
  - McandReg <<= STEP; MultReg >>= STEP; Count++.
  - Go to FIX when Count == XLEN/STEP−1 (last iteration) or on the early-out condition (see Configuration).
- **FIX.**
  - If Neg, Acc = −Acc (two's complement, 2·XLEN bits).
  - Go to DONE.
- **DONE.**
  - When ~StallM: ProdM ← Acc, go to IDLE.
  - When StallM: hold DONE and Acc.
- **MulBusyE** = (IDLE & MulStartE) | BUSY | FIX. It is deasserted in DONE so the instruction advances to M on the capturing edge.
- **Flush and reset.**
  - FlushE in any state → IDLE next cycle; Acc contents are don't-care; ProdM untouched.
  - FlushM → ProdM = 0 next edge; this has priority over the DONE capture.
  - reset → IDLE, Count = 0, Acc = 0, ProdM = 0, MulBusyE = 0 (MulBusyE may be 1 only combinationally via IDLE & MulStartE).
- **Simultaneous events.**
  - FlushE with MulStartE in IDLE: no start.
  - MulStartE in DONE is ignored. A back-to-back multiply starts from IDLE the following cycle.

## Timing
- Start cycle (IDLE) + XLEN/STEP BUSY cycles + FIX + DONE.
- The instruction spends XLEN/STEP+3 cycles in E with StallM low. For XLEN=64 and STEP=2 that is 35 cycles, of which MulBusyE is high for 34.
- ProdM is valid the cycle after DONE with ~StallM.
- No combinational path from ForwardedSrc*E to MulBusyE.

## Configuration
- **MUL_EARLY_OUT_EN defined:** in BUSY, if the post-shift MultReg == 0, go to FIX immediately. At least one BUSY cycle is always executed.
- **MUL_EARLY_OUT_EN undefined:** fixed latency of exactly XLEN/STEP BUSY cycles. No zero-detect logic is generated.

## Structure
- Package mulseq_pkg holds:
  - statetype enum {IDLE, BUSY, FIX, DONE}.
  - Funct3 localparams MUL_F3, MULH_F3, MULHSU_F3, MULHU_F3.
- Sub-module mulstep is the combinational STEP-bit conditional shift-add (Acc, McandReg, MultReg[STEP−1:0] → next Acc).
- ProdM uses flopenrc, with enable (DONE & ~StallM) and clear FlushM.

## Test plan
XLEN=64, STEP=2 unless noted.
- **MUL, early-out undefined:** A=7, B=−3 → ProdM = 0xFFFF…FFEB (−21, 128-bit); MulBusyE high exactly 34 cycles.
- **MULHU:** A=B=0xFFFF_FFFF_FFFF_FFFF → ProdM = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- **MULHSU:** A=−1, B=0x8000_0000_0000_0000 → ProdM = 0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000.
- **FlushE in BUSY at iteration 10** → IDLE next cycle, MulBusyE=0, ProdM unchanged. A following MUL 6×7 gives ProdM = 42.
- **StallM high 3 cycles in DONE** → state stays DONE; ProdM captures once on the first ~StallM edge. FlushM on that same edge gives ProdM = 0.
- **MUL_EARLY_OUT_EN defined:** MUL 3×5 → two BUSY cycles, MulBusyE high 4 cycles, ProdM = 15. Reset asserted mid-BUSY → IDLE, ProdM = 0.
